// File: rtl/fetch_instruction_buffer.sv
// Circular instruction queue between the 5-wide fetch and 3-wide decode stages.
// Optional performance counters are enabled with the IBUF_PERF_EN macro.
module fetch_instruction_buffer #(
    parameter int unsigned size  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [4:0]      fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [size-1:0] instr_i_0, instr_i_1, instr_i_2, instr_i_3, instr_i_4,
    input  logic [size-1:0] imm_i_0, imm_i_1, imm_i_2, imm_i_3, imm_i_4,
    input  logic [size-1:0] pc_i_0, pc_i_1, pc_i_2, pc_i_3, pc_i_4,
    input  logic [size-1:0] pred_pc_i_0, pred_pc_i_1, pred_pc_i_2, pred_pc_i_3, pred_pc_i_4,
    input  logic            pred_taken_i_0, pred_taken_i_1, pred_taken_i_2,
    input  logic            pred_taken_i_3, pred_taken_i_4,
    output logic [2:0]      dec_valid_o,
    input  logic            dec_ready_i,
    output logic [size-1:0] instr_o_0, instr_o_1, instr_o_2,
    output logic [size-1:0] imm_o_0, imm_o_1, imm_o_2,
    output logic [size-1:0] pc_o_0, pc_o_1, pc_o_2,
    output logic [size-1:0] pred_pc_o_0, pred_pc_o_1, pred_pc_o_2,
    output logic            pred_taken_o_0, pred_taken_o_1, pred_taken_o_2
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     empty_cnt_o,
    output logic [15:0]     flush_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 4 * size + 1;
    localparam int unsigned FW = 5;
    localparam int unsigned DW = 3;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [EW-1:0] w_wr_ent [FW];
    logic [EW-1:0] w_rd_ent [DW];
    logic [2:0]    w_n_raw;
    logic [2:0]    w_n_in;
    logic [1:0]    w_n_out;
    logic          w_run;

    // Entry layout: {taken, pred_pc, pc, imm, instr}
    assign w_wr_ent[0] = {pred_taken_i_0, pred_pc_i_0, pc_i_0, imm_i_0, instr_i_0};
    assign w_wr_ent[1] = {pred_taken_i_1, pred_pc_i_1, pc_i_1, imm_i_1, instr_i_1};
    assign w_wr_ent[2] = {pred_taken_i_2, pred_pc_i_2, pc_i_2, imm_i_2, instr_i_2};
    assign w_wr_ent[3] = {pred_taken_i_3, pred_pc_i_3, pc_i_3, imm_i_3, instr_i_3};
    assign w_wr_ent[4] = {pred_taken_i_4, pred_pc_i_4, pc_i_4, imm_i_4, instr_i_4};

    // Count leading ones of the fetch valid vector; bits after the first zero are ignored.
    always_comb begin
        w_n_raw = 3'd0;
        w_run   = 1'b1;
        for (int k = 0; k < int'(FW); k++) begin
            if (w_run && fetch_valid_i[k]) begin
                w_n_raw = w_n_raw + 3'd1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign fetch_ready_o = (r_count <= CW'(DEPTH - FW));
    assign w_n_in        = (fetch_ready_o && !flush) ? w_n_raw : 3'd0;

    for (genvar g = 0; g < int'(DW); g++) begin : g_rd
        assign dec_valid_o[g] = (r_count > CW'(g)) && !flush;
        assign w_rd_ent[g]    = r_mem[PW'(r_head + PW'(g))];
    end

    assign w_n_out = dec_ready_i
                   ? (2'(dec_valid_o[0]) + 2'(dec_valid_o[1]) + 2'(dec_valid_o[2]))
                   : 2'd0;

    assign {pred_taken_o_0, pred_pc_o_0, pc_o_0, imm_o_0, instr_o_0} = w_rd_ent[0];
    assign {pred_taken_o_1, pred_pc_o_1, pc_o_1, imm_o_1, instr_o_1} = w_rd_ent[1];
    assign {pred_taken_o_2, pred_pc_o_2, pc_o_2, imm_o_2, instr_o_2} = w_rd_ent[2];

    // Storage is not reset; only entries covered by count are ever presented as valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(FW); k++) begin
            if (3'(k) < w_n_in) begin
                r_mem[PW'(r_tail + PW'(k))] <= w_wr_ent[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_out);
            r_tail  <= r_tail + PW'(w_n_in);
            r_count <= r_count + CW'(w_n_in) - CW'(w_n_out);
        end
    end

`ifdef IBUF_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_empty_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating event counters; flush does not clear them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_empty_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!fetch_ready_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((r_count == '0) && dec_ready_i && (r_empty_cnt != '1)) begin
                r_empty_cnt <= r_empty_cnt + 32'd1;
            end
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign empty_cnt_o = r_empty_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_instruction_buffer.sv
// Bench for fetch_instruction_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_instruction_buffer;

    localparam int unsigned SZ = 32;
    localparam int unsigned D  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [4:0]    fv = 5'd0;
    logic          dr = 1'b0;
    logic          fr;
    logic [2:0]    dv;
    logic [SZ-1:0] instr_in [5];
    logic [SZ-1:0] imm_in   [5];
    logic [SZ-1:0] pc_in    [5];
    logic [SZ-1:0] ppc_in   [5];
    logic          tk_in    [5];
    logic [SZ-1:0] instr_o  [3];
    logic [SZ-1:0] imm_o    [3];
    logic [SZ-1:0] pc_o     [3];
    logic [SZ-1:0] ppc_o    [3];
    logic          tk_o     [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [$];
    int m_in;
    int m_out;
    bit m_run;

    fetch_instruction_buffer #(.size(SZ), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fetch_valid_i(fv), .fetch_ready_o(fr),
        .instr_i_0(instr_in[0]), .instr_i_1(instr_in[1]), .instr_i_2(instr_in[2]),
        .instr_i_3(instr_in[3]), .instr_i_4(instr_in[4]),
        .imm_i_0(imm_in[0]), .imm_i_1(imm_in[1]), .imm_i_2(imm_in[2]),
        .imm_i_3(imm_in[3]), .imm_i_4(imm_in[4]),
        .pc_i_0(pc_in[0]), .pc_i_1(pc_in[1]), .pc_i_2(pc_in[2]),
        .pc_i_3(pc_in[3]), .pc_i_4(pc_in[4]),
        .pred_pc_i_0(ppc_in[0]), .pred_pc_i_1(ppc_in[1]), .pred_pc_i_2(ppc_in[2]),
        .pred_pc_i_3(ppc_in[3]), .pred_pc_i_4(ppc_in[4]),
        .pred_taken_i_0(tk_in[0]), .pred_taken_i_1(tk_in[1]), .pred_taken_i_2(tk_in[2]),
        .pred_taken_i_3(tk_in[3]), .pred_taken_i_4(tk_in[4]),
        .dec_valid_o(dv), .dec_ready_i(dr),
        .instr_o_0(instr_o[0]), .instr_o_1(instr_o[1]), .instr_o_2(instr_o[2]),
        .imm_o_0(imm_o[0]), .imm_o_1(imm_o[1]), .imm_o_2(imm_o[2]),
        .pc_o_0(pc_o[0]), .pc_o_1(pc_o[1]), .pc_o_2(pc_o[2]),
        .pred_pc_o_0(ppc_o[0]), .pred_pc_o_1(ppc_o[1]), .pred_pc_o_2(ppc_o[2]),
        .pred_taken_o_0(tk_o[0]), .pred_taken_o_1(tk_o[1]), .pred_taken_o_2(tk_o[2])
    );

    always #5 clk = ~clk;

    // Every field of an entry is derived from its PC so the model only tracks PCs.
    function automatic logic [31:0] f_instr(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] pc);   return pc + 32'h0000_1000; endfunction
    function automatic logic [31:0] f_ppc(input logic [31:0] pc);   return pc + 32'h0000_0040; endfunction
    function automatic logic        f_tk(input logic [31:0] pc);    return pc[2] ^ pc[4]; endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [31:0] pc0, input logic d, input logic f);
        fv    = v;
        dr    = d;
        flush = f;
        for (int k = 0; k < 5; k++) begin
            pc_in[k]    = pc0 + 32'(4 * k);
            instr_in[k] = f_instr(pc_in[k]);
            imm_in[k]   = f_imm(pc_in[k]);
            ppc_in[k]   = f_ppc(pc_in[k]);
            tk_in[k]    = f_tk(pc_in[k]);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain FIFO of PCs with the fetch/decode handshake rules.
    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            mq.delete();
        end else begin
            m_in  = 0;
            m_run = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (m_run && fv[k]) m_in++;
                else m_run = 1'b0;
            end
            if (int'(D) - mq.size() < 5) m_in = 0;
            m_out = dr ? ((mq.size() < 3) ? mq.size() : 3) : 0;
            for (int k = 0; k < m_out; k++) void'(mq.pop_front());
            for (int k = 0; k < m_in; k++) mq.push_back(pc_in[k]);
        end
    end

    // Compare DUT outputs to the model mid-cycle.
    always @(negedge clk) begin
        chk("fetch_ready", 32'(fr), 32'((int'(D) - mq.size()) >= 5));
        for (int k = 0; k < 3; k++) begin
            if (!flush && (mq.size() > k)) begin
                chk("dec_valid", 32'(dv[k]), 32'd1);
                chk("pc_o", pc_o[k], mq[k]);
                chk("instr_o", instr_o[k], f_instr(mq[k]));
                chk("imm_o", imm_o[k], f_imm(mq[k]));
                chk("pred_pc_o", ppc_o[k], f_ppc(mq[k]));
                chk("pred_taken_o", 32'(tk_o[k]), 32'(f_tk(mq[k])));
            end else begin
                chk("dec_valid", 32'(dv[k]), 32'd0);
            end
        end
    end

    logic [4:0] mix_fv [12] = '{5'b11111, 5'b00111, 5'b11111, 5'b00001, 5'b11011, 5'b11111,
                                5'b00011, 5'b11111, 5'b01111, 5'b00000, 5'b11111, 5'b10001};
    logic       mix_dr [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        drive(5'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        reset = 1'b1;

        repeat (3) begin
            next_cycle();
            chk("idle_ready", 32'(fr), 32'd1);
            chk("idle_valid", 32'(dv), 32'd0);
        end

        // Five-entry group drained by a continuously ready decode.
        drive(5'b11111, 32'h0, 1'b1, 1'b0);
        next_cycle();
        drive(5'd0, 32'h0, 1'b1, 1'b0);
        chk("grp_valid0", 32'(dv), 32'b111);
        chk("grp_pc0", pc_o[0], 32'h0);
        chk("grp_pc1", pc_o[1], 32'h4);
        chk("grp_pc2", pc_o[2], 32'h8);
        next_cycle();
        chk("grp_valid1", 32'(dv), 32'b011);
        chk("grp_pc3", pc_o[0], 32'hC);
        chk("grp_pc4", pc_o[1], 32'h10);
        next_cycle();
        chk("grp_valid2", 32'(dv), 32'b000);

        // Non-prefix valid vector enqueues only the leading ones.
        drive(5'b10111, 32'h100, 1'b0, 1'b0);
        next_cycle();
        drive(5'd0, 32'h0, 1'b0, 1'b0);
        chk("pfx_valid", 32'(dv), 32'b111);
        chk("pfx_pc2", pc_o[2], 32'h108);
        drive(5'd0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        chk("pfx_drained", 32'(dv), 32'b000);

        // Fill to 15 with decode stalled; further writes are dropped; drain across the wrap.
        for (int i = 0; i < 3; i++) begin
            drive(5'b11111, 32'h200 + 32'(20 * i), 1'b0, 1'b0);
            next_cycle();
        end
        chk("full_ready", 32'(fr), 32'd0);
        drive(5'b11111, 32'h300, 1'b0, 1'b0);
        next_cycle();
        chk("drop_ready", 32'(fr), 32'd0);
        drive(5'd0, 32'h0, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            chk("wrap_pc_head", pc_o[0], 32'h200 + 32'(12 * j));
            next_cycle();
        end
        chk("wrap_empty", 32'(dv), 32'b000);

        // Flush with count 10 and a full same-cycle write.
        drive(5'b11111, 32'h400, 1'b0, 1'b0);
        next_cycle();
        drive(5'b11111, 32'h414, 1'b0, 1'b0);
        next_cycle();
        drive(5'b11111, 32'h500, 1'b0, 1'b1);
        #1;
        chk("flush_comb_valid", 32'(dv), 32'b000);
        next_cycle();
        drive(5'd0, 32'h0, 1'b0, 1'b0);
        chk("flush_valid", 32'(dv), 32'b000);
        chk("flush_ready", 32'(fr), 32'd1);
        next_cycle();
        chk("flush_no_write", 32'(dv), 32'b000);

        // Asynchronous reset in the middle of a burst.
        drive(5'b11111, 32'h600, 1'b1, 1'b0);
        repeat (3) next_cycle();
        #1;
        reset = 1'b0;
        #1;
        chk("areset_valid", 32'(dv), 32'b000);
        chk("areset_ready", 32'(fr), 32'd1);
        next_cycle();
        reset = 1'b1;
        drive(5'b00001, 32'h700, 1'b0, 1'b0);
        next_cycle();
        drive(5'd0, 32'h0, 1'b0, 1'b0);
        chk("post_reset_valid", 32'(dv), 32'b001);
        chk("post_reset_pc", pc_o[0], 32'h700);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 12; i++) begin
            drive(mix_fv[i], 32'h800 + 32'(32 * i), mix_dr[i], 1'b0);
            next_cycle();
        end
        drive(5'd0, 32'h0, 1'b1, 1'b0);
        repeat (8) next_cycle();
        chk("final_empty", 32'(dv), 32'b000);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
